paratoserial_nlane: RTL



---
 rtl/paratoserial_nlane.sv | 66 ++++++
 1 files changed

// File: rtl/paratoserial_nlane.sv
// paratoserial_nlane: LANES-wide MSB-first serializer driven by a bit counter,
// with COM link training, per-lane enable/valid and on-demand resync.
module paratoserial_nlane #(
   parameter int              WIDTH      = 8,
   parameter int              LANES      = 2,
   parameter int              SYNC_WORDS = 4,
   parameter logic [WIDTH-1:0] COM       = 8'hBC,
   parameter logic [WIDTH-1:0] IDLE      = 8'h7C
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic [LANES-1:0]       in_valid,
   input  logic [LANES-1:0]       lane_en,
   input  logic                   resync,
   output logic                   word_req,
   output logic                   active,
   output logic [LANES-1:0]       ser_out
);
   localparam int CW = $clog2(WIDTH);
   localparam int SW = $clog2(SYNC_WORDS + 1);
   typedef enum logic {SYNC, ACTIVE} state_t;
   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [SW-1:0]               sync_q, sync_d, sync_inc;
   logic                        pend_q, pend_d, restart, com_load;
   logic [LANES-1:0][WIDTH-1:0] sr_q, sr_d;
   always_comb begin
      word_req = cnt_q == CW'(WIDTH - 1);
      cnt_d    = word_req ? '0 : cnt_q + CW'(1);
      restart  = pend_q | resync;
      com_load = restart | (state_q == SYNC);
      // a resync load is itself COM #1, so counting restarts from zero
      sync_inc = (restart ? '0 : sync_q) + SW'(1);
      pend_d   = !word_req & (pend_q | resync);
      state_d  = state_q;
      sync_d   = sync_q;
      if (word_req && com_load) begin
         state_d = (sync_inc == SW'(SYNC_WORDS)) ? ACTIVE : SYNC;
         sync_d  = (sync_inc == SW'(SYNC_WORDS)) ? '0 : sync_inc;
      end
      for (int k = 0; k < LANES; k++) begin
         sr_d[k]    = word_req ? (!lane_en[k] ? '0 :
                                  com_load    ? COM :
                                  in_valid[k] ? in_data[k*WIDTH +: WIDTH] : IDLE)
                               : {sr_q[k][WIDTH-2:0], 1'b0};
         ser_out[k] = sr_q[k][WIDTH-1];
      end
      active = state_q == ACTIVE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SYNC;
         cnt_q   <= '0;
         sync_q  <= '0;
         pend_q  <= 1'b0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= sync_d;
         pend_q  <= pend_d;
         sr_q    <= sr_d;
      end
   end
endmodule
